// File: rtl/reg32_arb_pkg.sv
// Shared encodings and sizes for the byte-lane write arbiter around a 32-bit register.
package reg32_arb_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 8;
  localparam int unsigned DATA_W    = NUM_LANES * LANE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

endpackage : reg32_arb_pkg

// File: rtl/reg32_arbiter_reg8_be.sv
// One byte lane of the shared register: synchronous reset to RST_VAL, load on we_i.
module reg8_be
  import reg32_arb_pkg::*;
#(
  parameter logic [LANE_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [LANE_W-1:0] d_i,
  output logic [LANE_W-1:0] q_o
);

  logic [LANE_W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= RST_VAL;
    end else if (we_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule : reg8_be

// File: rtl/reg32_arbiter.sv
// Two-requester round-robin arbiter writing byte-enabled data into a shared 32-bit register.
// Optional REG32_ARB_LOCK_EN adds lock0/lock1 to hold a grant across cycles.
module reg32_arbiter
  import reg32_arb_pkg::*;
#(
  parameter logic [DATA_W-1:0] INIT_VAL = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [DATA_W-1:0]    wdata0,
  input  logic [DATA_W-1:0]    wdata1,
  input  logic [NUM_LANES-1:0] be0,
  input  logic [NUM_LANES-1:0] be1,
`ifdef REG32_ARB_LOCK_EN
  input  logic                 lock0,
  input  logic                 lock1,
`endif
  output logic                 gnt0,
  output logic                 gnt1,
  output logic [DATA_W-1:0]    q,
  output logic                 last
);

  state_e state_q, state_d;
  logic   last_q, last_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Round-robin on a tie; a lone requester wins regardless of history.
  always_comb begin
    state_d = IDLE;
    last_d  = last_q;
    if (req0 && req1) begin
      state_d = last_q ? G0 : G1;
    end else if (req0) begin
      state_d = G0;
    end else if (req1) begin
      state_d = G1;
    end
`ifdef REG32_ARB_LOCK_EN
    if (state_q == G0 && req0 && lock0) begin
      state_d = G0;
    end
    if (state_q == G1 && req1 && lock1) begin
      state_d = G1;
    end
`endif
    if (state_d == G0) begin
      last_d = 1'b0;
    end else if (state_d == G1) begin
      last_d = 1'b1;
    end
  end

  assign gnt0 = (state_q == G0);
  assign gnt1 = (state_q == G1);
  assign last = last_q;

  logic [NUM_LANES-1:0] lane_we;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [LANE_W-1:0] lane_d;

    assign lane_we[i] = (gnt0 & be0[i]) | (gnt1 & be1[i]);
    assign lane_d     = gnt1 ? wdata1[i*LANE_W +: LANE_W] : wdata0[i*LANE_W +: LANE_W];

    reg8_be #(
      .RST_VAL (INIT_VAL[i*LANE_W +: LANE_W])
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .we_i  (lane_we[i]),
      .d_i   (lane_d),
      .q_o   (q[i*LANE_W +: LANE_W])
    );
  end

endmodule : reg32_arbiter

// File: tb/tb_reg32_arbiter.sv
// Scoreboard bench for reg32_arbiter: a cycle model predicts outputs, which are compared a cycle later.
module tb_reg32_arbiter;

  localparam logic [31:0] INIT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  be0, be1;
  logic        gnt0, gnt1, last;
  logic [31:0] q;
`ifdef REG32_ARB_LOCK_EN
  logic        lock0, lock1;
`endif

  always #5 clk = ~clk;

  reg32_arbiter #(.INIT_VAL(INIT)) dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .req1   (req1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .be0    (be0),
    .be1    (be1),
`ifdef REG32_ARB_LOCK_EN
    .lock0  (lock0),
    .lock1  (lock1),
`endif
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .q      (q),
    .last   (last)
  );

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic        lst;
    logic [31:0] q;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;

  // Reference model state: 0 idle, 1 serving requester 0, 2 serving requester 1.
  int          m_st;
  logic        m_last;
  logic [31:0] m_q;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic model_step();
    int          nst;
    logic [31:0] nq;
    exp_t        e;
    if (reset) begin
      m_q    = INIT;
      m_st   = 0;
      m_last = 1'b1;
    end else begin
      nq = m_q;
      for (int b = 0; b < 4; b++) begin
        if (m_st == 1 && be0[b]) nq[8*b +: 8] = wdata0[8*b +: 8];
        if (m_st == 2 && be1[b]) nq[8*b +: 8] = wdata1[8*b +: 8];
      end
      nst = 0;
      if (req0 && req1)  nst = (m_last == 1'b1) ? 1 : 2;
      else if (req0)     nst = 1;
      else if (req1)     nst = 2;
`ifdef REG32_ARB_LOCK_EN
      if (m_st == 1 && req0 && lock0) nst = 1;
      if (m_st == 2 && req1 && lock1) nst = 2;
`endif
      if (nst != 0) m_last = (nst == 2);
      m_st = nst;
      m_q  = nq;
    end
    e.g0  = (m_st == 1);
    e.g1  = (m_st == 2);
    e.lst = m_last;
    e.q   = m_q;
    sb.push_back(e);
  endtask

  // Predict with the inputs now applied, clock once, compare at the falling edge.
  task automatic cyc(input string tag);
    exp_t e;
    model_step();
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check_eq({tag, "_gnt0"}, 32'(gnt0), 32'(e.g0));
    check_eq({tag, "_gnt1"}, 32'(gnt1), 32'(e.g1));
    check_eq({tag, "_last"}, 32'(last), 32'(e.lst));
    check_eq({tag, "_q"},    q,         e.q);
  endtask

  initial begin
    logic [3:0] seq;
    int         g0_cnt;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    wdata0 = '0; wdata1 = '0; be0 = '0; be1 = '0;
`ifdef REG32_ARB_LOCK_EN
    lock0 = 1'b0; lock1 = 1'b0;
`endif

    cyc("reset");
    check_eq("reset_q_const", q, 32'hDEAD_BEEF);
    check_eq("reset_last_const", 32'(last), 32'd1);

    // Single full-word write from requester 0.
    reset = 1'b0; req0 = 1'b1; wdata0 = 32'h1122_3344; be0 = 4'hF;
    cyc("w0_grant");
    check_eq("w0_gnt_const", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    cyc("w0_data");
    check_eq("w0_q_const", q, 32'h1122_3344);

    // Partial write from requester 1.
    req1 = 1'b1; wdata1 = 32'hAABB_CCDD; be1 = 4'b0101;
    cyc("w1_grant");
    req1 = 1'b0;
    cyc("w1_data");
    check_eq("w1_q_const", q, 32'h11BB_33DD);

    // Both held: grants alternate starting with requester 0.
    seq = '0;
    req0 = 1'b1; req1 = 1'b1; wdata0 = 32'h0101_0101; wdata1 = 32'h0202_0202;
    be0 = 4'b0011; be1 = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      cyc("rr");
      seq = {seq[2:0], gnt0};
    end
    check_eq("rr_seq", 32'(seq), 32'(4'b1010));
    req0 = 1'b0; req1 = 1'b0;
    cyc("rr_tail");
    cyc("rr_idle");

    // Empty byte enables still take a grant cycle and leave q intact.
    req0 = 1'b1; be0 = 4'b0000; wdata0 = 32'hFFFF_FFFF;
    cyc("be0_grant");
    req0 = 1'b0;
    cyc("be0_data");

    // Back-to-back grants to a lone requester.
    req1 = 1'b1; be1 = 4'b1000; wdata1 = 32'h7700_0000;
    for (int i = 0; i < 3; i++) cyc("solo");
    req1 = 1'b0;
    cyc("solo_tail");

    // Reset during a grant cycle discards the write; requests ignored while held.
    req1 = 1'b1; wdata1 = 32'hFFFF_FFFF; be1 = 4'hF;
    cyc("rst_g1");
    reset = 1'b1;
    cyc("rst_abort");
    check_eq("rst_abort_q_const", q, 32'hDEAD_BEEF);
    check_eq("rst_abort_gnt1_const", 32'(gnt1), 32'd0);
    req0 = 1'b1;
    cyc("rst_hold");
    reset = 1'b0; req0 = 1'b0;
    cyc("rst_resume");
    req1 = 1'b0;
    cyc("rst_resume_data");

`ifdef REG32_ARB_LOCK_EN
    // Locked requester 0 keeps the grant while requester 1 waits.
    reset = 1'b1;
    cyc("lk_reset");
    reset = 1'b0;
    g0_cnt = 0;
    req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1;
    wdata0 = 32'h1234_5678; be0 = 4'hF;
    for (int i = 0; i < 3; i++) begin
      cyc("lk_hold");
      if (gnt0) g0_cnt++;
    end
    check_eq("lk_g0_count", 32'(g0_cnt), 32'd3);
    req0 = 1'b0; lock0 = 1'b0;
    cyc("lk_switch");
    check_eq("lk_gnt1_const", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    cyc("lk_tail");
`else
    g0_cnt = 0;
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 39) == 0);
      req0   = $urandom_range(0, 2) != 0;
      req1   = $urandom_range(0, 2) != 0;
      wdata0 = $urandom;
      wdata1 = $urandom;
      be0    = 4'($urandom_range(0, 15));
      be1    = 4'($urandom_range(0, 15));
`ifdef REG32_ARB_LOCK_EN
      lock0  = $urandom_range(0, 1) != 0;
      lock1  = $urandom_range(0, 1) != 0;
`endif
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_reg32_arbiter

// File: doc/reg32_arbiter.md
REG32_ARBITER -- requirements
Module: reg32_arbiter

Interface
REQ-001 SHALL have parameter INIT_VAL, default 32'h0000_0000: value loaded into q on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0, req1  input  1 each  write request from requester 0 or 1; held until granted.
REQ-005 SHALL have ports wdata0, wdata1  input  32 each  write data from each requester.
REQ-006 SHALL have ports be0, be1  input  4 each  byte enables; bit i covers byte [8i+7:8i].
REQ-007 SHALL have ports gnt0, gnt1  output  1 each  registered grant; one-hot or both 0.
REQ-008 SHALL have port q  output  32  current contents of the shared 32-bit register.
REQ-009 SHALL have port last  output  1  index of the most recently granted requester.

Function
REQ-010 SHALL implement an FSM with states IDLE, G0 and G1; gnt0=1 only in G0 and gnt1=1 only in G1.
REQ-011 SHALL transition from IDLE to G0 or G1 on the next edge when a request is present, and stay in IDLE otherwise.
REQ-012 SHALL transition from G0 or G1 on the next edge by applying the same arbitration to req0/req1, returning to IDLE when neither is asserted.
REQ-013 SHALL, when req0 and req1 are both asserted, grant the requester not equal to last (round-robin).
REQ-014 SHALL, when exactly one request is asserted, grant that requester regardless of last, so consecutive grants to the same requester are legal.
REQ-015 SHALL, in G0, write the lanes selected by be0 from wdata0 into q at the edge ending the cycle; G1 uses be1/wdata1 in the same way.
REQ-016 SHALL leave lanes with byte enable 0 unchanged; be=4'b0000 still consumes the grant cycle.
REQ-017 SHALL make the written value visible on q on the edge that ends the grant cycle.
REQ-018 SHALL give request-to-grant latency of exactly 1 cycle from IDLE and sustain one write per cycle under continuous requests.
REQ-019 SHALL update last to the granted index on every edge that enters G0 or G1, and hold it otherwise.
REQ-020 SHALL treat a requester as served when its gnt is high; the requester drops req on the following cycle or issues a new write.

Reset
REQ-021 SHALL, when reset=1 at an edge, set q=INIT_VAL, state=IDLE, gnt0=gnt1=0 and last=1, so requester 0 wins the first tie.
REQ-022 SHALL let reset override everything: reset asserted during a grant cycle discards the pending write.
REQ-023 SHALL ignore requests in the cycle reset is high, with arbitration resuming on the first edge after reset deasserts.

Configuration
REQ-024 SHALL support macro REG32_ARB_LOCK_EN; when it is defined, input ports lock0 and lock1 (1 bit each) SHALL exist.
REQ-025 SHALL, with REG32_ARB_LOCK_EN defined, keep the FSM in Gx while the granted requester holds reqx=1 and lockx=1, even when the other requester is waiting.
REQ-026 SHALL, without REG32_ARB_LOCK_EN, omit the lock ports and use pure round-robin as specified in REQ-013.

Structure
REQ-027 SHALL place the state encodings (IDLE=2'd0, G0=2'd1, G1=2'd2) and the lane count 4 in shared package reg32_arb_pkg.
REQ-028 SHALL instantiate 4 copies of the sub-module reg8_be (an 8-bit register with synchronous reset, reset value and write enable), one per byte lane.
REQ-029 SHALL generate the arbitration and the per-lane enables (gntx AND bex[i]) in reg32_arbiter.

Verification
REQ-030 SHALL cover: reset with INIT_VAL=32'hDEAD_BEEF -> q=32'hDEADBEEF, gnt0=gnt1=0, last=1.
REQ-031 SHALL cover: req0 with wdata0=32'h1122_3344 and be0=4'hF -> gnt0 after 1 cycle, then q=32'h11223344.
REQ-032 SHALL cover: req0 and req1 held for 4 cycles -> grants alternate 0,1,0,1.
REQ-033 SHALL cover: q=32'h11223344, then req1 with wdata1=32'hAABB_CCDD and be1=4'b0101 -> q=32'h11BB33DD.
REQ-034 SHALL cover: reset asserted during a G1 cycle with wdata1=32'hFFFF_FFFF -> q=INIT_VAL and state IDLE.
REQ-035 SHALL cover, with REG32_ARB_LOCK_EN defined: req0 with lock0=1 for 3 cycles while req1=1 -> gnt0 for 3 cycles, then gnt1.
